matrix_mul_ctrl: RTL and testbench

MATRIX_MUL_CTRL -- requirements
Module: matrix_mul_ctrl

---
 rtl/matrix_mul_ctrl.sv | 127 ++++++++++++
 tb/tb_matrix_mul_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mul_ctrl.sv
// 4x4 single-precision matrix product sequencer driving an external dot-product unit.
// Optional WAIT watchdog enabled by defining MATRIX_MUL_CTRL_TIMEOUT_EN.
module matrix_mul_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] mat_a,
  input  logic [511:0] mat_b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [511:0] mat_c,
  output logic [127:0] row_a,
  output logic [127:0] col_b,
  output logic         dp_valid,
  input  logic [31:0]  dp_result,
  input  logic         dp_rdy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e       state_q, state_d;
  logic [511:0] a_q, b_q, res_q;
  logic [1:0]   row_q, col_q;
  logic         last_elem;
  logic         accept;
  logic         timeout;

  assign last_elem = (row_q == 2'd3) && (col_q == 2'd3);
  assign accept    = (state_q == StIdle) && start;

`ifdef MATRIX_MUL_CTRL_TIMEOUT_EN
  logic [7:0] wdog_q;
  logic       err_q;

  // 256th consecutive WAIT cycle without dp_rdy
  assign timeout = (state_q == StWait) && !dp_rdy && (wdog_q == 8'hff);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wdog_q <= '0;
      end else if (state_q == StWait) begin
        wdog_q <= wdog_q + 8'd1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (dp_rdy) begin
          state_d = last_elem ? StDone : StIssue;
        end else if (timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      a_q   <= mat_a;
      b_q   <= mat_b;
      res_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if ((state_q == StWait) && dp_rdy) begin
      res_q[{row_q, col_q, 5'd0} +: 32] <= dp_result;
      // Indices stay at (3,3) after the final element
      if (!last_elem) begin
        col_q <= col_q + 2'd1;
        if (col_q == 2'd3) begin
          row_q <= row_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    row_a = '0;
    col_b = '0;
    for (int k = 0; k < 4; k++) begin
      row_a[k*32 +: 32] = a_q[{row_q, 2'(k), 5'd0} +: 32];
      col_b[k*32 +: 32] = b_q[{2'(k), col_q, 5'd0} +: 32];
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign dp_valid = (state_q == StIssue);
  assign mat_c    = res_q;

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// Scoreboard bench for matrix_mul_ctrl with a behavioural dot-product unit.
// Timeout scenario runs only when MATRIX_MUL_CTRL_TIMEOUT_EN is defined.
module tb_matrix_mul_ctrl;

  localparam logic [31:0] One = 32'h3f800000;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [511:0] mat_a, mat_b, mat_c;
  logic         busy, done, err, dp_valid, dp_rdy;
  logic [127:0] row_a, col_b;
  logic [31:0]  dp_result;

  int checks = 0;
  int failures = 0;
  int dp_delay = 1;
  int stall_idx = -1;
  int vcount = 0;

  logic [255:0] op_q[$];
  logic [511:0] c_exp_q[$];
  logic [511:0] last_exp;

  matrix_mul_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mat_c     (mat_c),
    .row_a     (row_a),
    .col_b     (col_b),
    .dp_valid  (dp_valid),
    .dp_result (dp_result),
    .dp_rdy    (dp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_of(input logic [511:0] m, input int r);
    return m[r*128 +: 128];
  endfunction

  function automatic logic [127:0] col_of(input logic [511:0] m, input int c);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[k*32 +: 32] = m[(k*4+c)*32 +: 32];
    return v;
  endfunction

  // Exact for operands in {0.0, 1.0}; otherwise a mixing hash of the lanes
  function automatic logic [31:0] dp_model(input logic [127:0] ra, input logic [127:0] cb);
    logic [31:0] a, b, h;
    int n = 0;
    bit simple = 1'b1;
    h = 32'h9e3779b9;
    for (int k = 0; k < 4; k++) begin
      a = ra[k*32 +: 32];
      b = cb[k*32 +: 32];
      if ((a != 0 && a != One) || (b != 0 && b != One)) simple = 1'b0;
      if (a == One && b == One) n++;
      h = {h[26:0], h[31:27]} ^ a ^ (b + 32'(k));
    end
    if (!simple) return h;
    case (n)
      0:       return 32'h0;
      1:       return 32'h3f800000;
      2:       return 32'h40000000;
      3:       return 32'h40400000;
      default: return 32'h40800000;
    endcase
  endfunction

  function automatic logic [511:0] ident();
    logic [511:0] m = '0;
    for (int i = 0; i < 4; i++) m[(i*4+i)*32 +: 32] = One;
    return m;
  endfunction

  function automatic logic [511:0] rand_mat();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic push_op(input logic [511:0] a, input logic [511:0] b, input int nops,
                         input int nres);
    logic [511:0] c = '0;
    for (int e = 0; e < nops; e++) op_q.push_back({row_of(a, e / 4), col_of(b, e % 4)});
    for (int e = 0; e < nres; e++) c[e*32 +: 32] = dp_model(row_of(a, e / 4), col_of(b, e % 4));
    c_exp_q.push_back(c);
  endtask

  // Behavioural dot-product unit: answers dp_delay cycles after dp_valid
  initial begin
    int cnt = 0;
    logic [31:0] res = '0;
    dp_rdy = 1'b0;
    dp_result = '0;
    forever begin
      @(posedge clk);
      #1;
      dp_rdy = 1'b0;
      if (dp_valid === 1'b1) begin
        cnt = (vcount == stall_idx) ? 0 : dp_delay;
        res = dp_model(row_a, col_b);
        vcount++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dp_rdy = 1'b1;
          dp_result = res;
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 512'({busy, done, err, dp_valid}), 512'(0));
    chk({tag, "_mat_c"}, mat_c, 512'(0));
    chk({tag, "_lanes"}, 512'({row_a, col_b}), 512'(0));
  endtask

  // Leaves the bench in cycle 1 (one edge after the start-sampling edge)
  task automatic start_op(input logic [511:0] a, input logic [511:0] b);
    vcount = 0;
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_busy", 512'(busy), 512'(1));
    chk("accept_clear", mat_c, 512'(0));
  endtask

  task automatic run_loop(input int max, input int poke, output int done_cyc, output int nvalid);
    int cyc = 1;
    bit busy_ok = 1'b1;
    logic [255:0] e;
    done_cyc = 0;
    nvalid = 0;
    forever begin
      if (dp_valid === 1'b1) begin
        nvalid++;
        if (op_q.size() == 0) begin
          chk("dp_valid_extra", 512'(1), 512'(0));
        end else begin
          e = op_q.pop_front();
          chk("operands", 512'({row_a, col_b}), 512'(e));
        end
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc >= max) break;
      start = (cyc == poke);
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end
    chk("busy_span", 512'(busy_ok), 512'(1));
  endtask

  task automatic check_result(input int done_cyc, input int exp_cyc, input int nvalid,
                              input int exp_n);
    chk("done_cycle", 512'(done_cyc), 512'(exp_cyc));
    chk("dp_valid_count", 512'(nvalid), 512'(exp_n));
    if (c_exp_q.size() == 0) begin
      chk("result_missing", 512'(1), 512'(0));
    end else begin
      last_exp = c_exp_q.pop_front();
      chk("mat_c", mat_c, last_exp);
    end
  endtask

  initial begin
    int dc, nv, extra;
    logic [511:0] a, b;

    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    int dc, nv, extra;
    logic [511:0] a, b;
    rst = 1'b1;
    start = 1'b0;
    mat_a = '0;
    mat_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identity product, single-cycle dot-product latency
    dp_delay = 1;
    a = ident();
    push_op(a, a, 16, 16);
    start_op(a, a);
    run_loop(60, -1, dc, nv);
    check_result(dc, 33, nv, 16);
    chk("identity", mat_c, ident());
    chk("err_idle", 512'(err), 512'(0));
    @(posedge clk);
    #1;
    chk("done_pulse", 512'({busy, done}), 512'(0));

    // Row-major sequencing, 3-cycle latency
    dp_delay = 3;
    for (int i = 0; i < 16; i++) a[i*32 +: 32] = 32'(i + 1);
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    run_loop(100, -1, dc, nv);
    check_result(dc, 65, nv, 16);
    @(posedge clk);
    #1;

    // Start while busy and in the DONE cycle
    dp_delay = 1;
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    mat_a = rand_mat();
    run_loop(60, 10, dc, nv);
    check_result(dc, 33, nv, 16);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("no_restart", 512'(busy), 512'(0));
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || dp_valid === 1'b1 || busy === 1'b1) extra++;
    end
    chk("ignored_activity", 512'(extra), 512'(0));
    chk("mat_c_held", mat_c, last_exp);

    // Reset while element (1,2) is outstanding, then a late dp_rdy
    dp_delay = 3;
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    run_loop(25, -1, dc, nv);
    chk("midrst_elems", 512'(nv), 512'(7));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("midrst");
    op_q.delete();
    c_exp_q.delete();
    extra = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || dp_valid === 1'b1 || busy === 1'b1) extra++;
    end
    chk("midrst_quiet", 512'(extra), 512'(0));
    chk_zero("midrst_late");

`ifdef MATRIX_MUL_CTRL_TIMEOUT_EN
    // dp_rdy never arrives for element (2,0)
    dp_delay = 1;
    stall_idx = 8;
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 9, 8);
    start_op(a, b);
    run_loop(400, -1, dc, nv);
    check_result(dc, 274, nv, 9);
    chk("timeout_err", 512'(err), 512'(1));
    @(posedge clk);
    #1;
    chk("err_sticky", 512'({err, busy}), 512'(2'b10));
    stall_idx = -1;
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    chk("err_clear", 512'(err), 512'(0));
    run_loop(60, -1, dc, nv);
    check_result(dc, 33, nv, 16);
    @(posedge clk);
    #1;
`endif

    // Back-to-back: second start in the cycle after done
    dp_delay = 1;
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    run_loop(60, -1, dc, nv);
    check_result(dc, 33, nv, 16);
    @(posedge clk);
    #1;
    chk("b2b_hold", mat_c, last_exp);
    a = rand_mat();
    b = rand_mat();
    push_op(a, b, 16, 16);
    start_op(a, b);
    run_loop(60, -1, dc, nv);
    check_result(dc, 33, nv, 16);
    chk("err_final", 512'(err), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
